cavlc_coeff_token_encoder: RTL and testbench
============================================

// Module: cavlc_coeff_token_encoder
// PURPOSE
//  Encoder-side counterpart of the CAVLC coeff_token decode LUTs: maps a
//  (TotalCoeff, TrailingOnes) pair to its H.264 Table 9-5 codeword for 0<=nC<2.
//  Emits the codeword MSB-first as a serial bitstream with valid/ready
//  backpressure, feeding the CAVLC bitstream writer.
// PARAMETERS
//  MAX_LEN  16  longest coeff_token codeword, in bits; sets shift register width
//  LEN_W    5   width of the internal length/bit counter (>= clog2(MAX_LEN+1))
// PORTS
//  Clk           in   1  clock; all logic on rising edge
//  nReset        in   1  asynchronous, active-low reset
//  TokenValid    in   1  input token present
//  TokenReady    out  1  encoder can accept a token this cycle
//  TotalCoeff    in   5  number of nonzero coefficients, 0..16
//  TrailingOnes  in   2  trailing +/-1 count, 0..3
//  BitValid      out  1  BitOut carries a valid codeword bit
//  BitReady      in   1  downstream consumes BitOut this cycle
//  BitOut        out  1  current codeword bit, MSB first
//  BitLast       out  1  qualifies the final bit of the codeword
//  TokenErr      out  1  one-cycle pulse: illegal token dropped
// BEHAVIOUR
//  Reset (async assert, sync deassert): state IDLE; TokenReady=1 after
//   deassert; BitValid=0, BitOut=0, BitLast=0, TokenErr=0; shift reg and
//   counter cleared.
//  FSM IDLE -> SHIFT -> IDLE:
//   IDLE:  TokenReady=1. On TokenValid: register codeword and length from the
//          combinational table. Left-align the codeword in the MAX_LEN shift
//          register and load Cnt=len. Go to SHIFT.
//   SHIFT: TokenReady=0, BitValid=1, BitOut=shreg[MAX_LEN-1], BitLast=(Cnt==1).
//          On BitReady: shift left by 1 and Cnt-=1. If Cnt==1, go to IDLE.
//  Latency: token accepted on edge T; first bit valid in cycle T+1. A len-L
//   codeword with BitReady tied high occupies cycles T+1..T+L. The next token
//   can be accepted at T+L+1, which leaves one bubble per token.
//  Backpressure: while BitValid=1 and BitReady=0, BitOut and BitLast hold.
//  Legal tokens: TrailingOnes<=3, TrailingOnes<=TotalCoeff, TotalCoeff<=16.
//   Codeword lengths are 1..16 and never 0.
//  Illegal token, accepted in IDLE: TokenErr=1 for exactly the next cycle. The
//   token is consumed, no bits are emitted, and the FSM stays in IDLE.
//  Table: full 62-entry Table 9-5 nC 0..2 column, hard-coded case on
//   {TotalCoeff,TrailingOnes}. Examples:
//   (0,0)=1/1  (1,1)=01/2  (2,2)=001/3  (3,3)=00011/5  (1,0)=000101/6
//   (2,1)=000100/6  (2,0)=00000111/8  (4,3)=000011/6
//  Inputs are sampled only in IDLE; TotalCoeff/TrailingOnes are don't-care
//   otherwise. TokenValid held during SHIFT is ignored and not lost; it is
//   accepted on return to IDLE.
//  nReset asserted mid-SHIFT: codeword aborted immediately. BitValid drops
//   asynchronously and no partial-codeword recovery is attempted.
//  Counter never wraps; Cnt==0 is unreachable in SHIFT (assertion in TB).
// TESTING
//  T1 reset: hold nReset=0 3 cycles with TokenValid=1 -> BitValid=0,
//     TokenErr=0; TokenReady=1 the cycle after release.
//  T2 (TotalCoeff=1,TrailingOnes=0), BitReady=1 -> BitOut 0,0,0,1,0,1 on
//     6 consecutive cycles; BitLast only on the 6th; TokenReady back on the 7th.
//  T3 (0,0), (3,3) back-to-back -> "1" with BitLast, 1 bubble, then 0,0,0,1,1;
//     total 8 cycles from first accept to TokenReady.
//  T4 (2,0) with BitReady toggling 1,0,0,1,... -> stream 00000111; BitOut
//     stable across stalls; 8 BitReady handshakes exactly.
//  T5 illegal (1,2) and (17,0) -> TokenErr=1 one cycle each, BitValid stays 0.
//  T6 nReset pulsed low at 3rd bit of (1,0) -> BitValid=0 at once; a following
//     (1,1) emits clean 0,1.

Source files
------------

// File: rtl/cavlc_coeff_token_encoder.sv
// cavlc_coeff_token_encoder
//   Maps a (TotalCoeff, TrailingOnes) pair to its H.264 coeff_token codeword
//   for the 0 <= nC < 2 table. The codeword is sent MSB-first, one bit per
//   handshake, on a valid/ready serial port that feeds the CAVLC bitstream
//   writer.
// Ports
//   Clk, nReset               clock (rising edge), async active-low reset
//   TokenValid/TokenReady     token handshake; a token is accepted only in IDLE
//   TotalCoeff[4:0]           nonzero coefficient count, 0..16
//   TrailingOnes[1:0]         trailing +/-1 count, 0..3
//   BitValid/BitReady         serial bit handshake
//   BitOut                    current codeword bit, MSB first
//   BitLast                   marks the final bit of the codeword
//   TokenErr                  one-cycle pulse after an illegal token is dropped
module cavlc_coeff_token_encoder #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       TokenValid,
  output logic       TokenReady,
  input  logic [4:0] TotalCoeff,
  input  logic [1:0] TrailingOnes,
  output logic       BitValid,
  input  logic       BitReady,
  output logic       BitOut,
  output logic       BitLast,
  output logic       TokenErr
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [MAX_LEN-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [4:0]  tab_len;
  logic [15:0] tab_code;

  // Codeword table, right-aligned value + length. Illegal pairs fall to the
  // default with length 0, which doubles as the illegal-token flag.
  always_comb begin : coeff_token_table
    tab_len  = 5'd0;
    tab_code = 16'd0;
    case ({TotalCoeff, TrailingOnes})
      {5'd0,  2'd0}: {tab_len, tab_code} = {5'd1,  16'd1};
      {5'd1,  2'd0}: {tab_len, tab_code} = {5'd6,  16'd5};
      {5'd1,  2'd1}: {tab_len, tab_code} = {5'd2,  16'd1};
      {5'd2,  2'd0}: {tab_len, tab_code} = {5'd8,  16'd7};
      {5'd2,  2'd1}: {tab_len, tab_code} = {5'd6,  16'd4};
      {5'd2,  2'd2}: {tab_len, tab_code} = {5'd3,  16'd1};
      {5'd3,  2'd0}: {tab_len, tab_code} = {5'd9,  16'd7};
      {5'd3,  2'd1}: {tab_len, tab_code} = {5'd8,  16'd6};
      {5'd3,  2'd2}: {tab_len, tab_code} = {5'd7,  16'd5};
      {5'd3,  2'd3}: {tab_len, tab_code} = {5'd5,  16'd3};
      {5'd4,  2'd0}: {tab_len, tab_code} = {5'd10, 16'd7};
      {5'd4,  2'd1}: {tab_len, tab_code} = {5'd9,  16'd6};
      {5'd4,  2'd2}: {tab_len, tab_code} = {5'd8,  16'd5};
      {5'd4,  2'd3}: {tab_len, tab_code} = {5'd6,  16'd3};
      {5'd5,  2'd0}: {tab_len, tab_code} = {5'd11, 16'd7};
      {5'd5,  2'd1}: {tab_len, tab_code} = {5'd10, 16'd6};
      {5'd5,  2'd2}: {tab_len, tab_code} = {5'd9,  16'd5};
      {5'd5,  2'd3}: {tab_len, tab_code} = {5'd7,  16'd4};
      {5'd6,  2'd0}: {tab_len, tab_code} = {5'd13, 16'd15};
      {5'd6,  2'd1}: {tab_len, tab_code} = {5'd11, 16'd6};
      {5'd6,  2'd2}: {tab_len, tab_code} = {5'd10, 16'd5};
      {5'd6,  2'd3}: {tab_len, tab_code} = {5'd8,  16'd4};
      {5'd7,  2'd0}: {tab_len, tab_code} = {5'd13, 16'd11};
      {5'd7,  2'd1}: {tab_len, tab_code} = {5'd13, 16'd14};
      {5'd7,  2'd2}: {tab_len, tab_code} = {5'd11, 16'd5};
      {5'd7,  2'd3}: {tab_len, tab_code} = {5'd9,  16'd4};
      {5'd8,  2'd0}: {tab_len, tab_code} = {5'd13, 16'd8};
      {5'd8,  2'd1}: {tab_len, tab_code} = {5'd13, 16'd10};
      {5'd8,  2'd2}: {tab_len, tab_code} = {5'd13, 16'd13};
      {5'd8,  2'd3}: {tab_len, tab_code} = {5'd10, 16'd4};
      {5'd9,  2'd0}: {tab_len, tab_code} = {5'd14, 16'd15};
      {5'd9,  2'd1}: {tab_len, tab_code} = {5'd14, 16'd14};
      {5'd9,  2'd2}: {tab_len, tab_code} = {5'd13, 16'd9};
      {5'd9,  2'd3}: {tab_len, tab_code} = {5'd11, 16'd4};
      {5'd10, 2'd0}: {tab_len, tab_code} = {5'd14, 16'd11};
      {5'd10, 2'd1}: {tab_len, tab_code} = {5'd14, 16'd10};
      {5'd10, 2'd2}: {tab_len, tab_code} = {5'd14, 16'd13};
      {5'd10, 2'd3}: {tab_len, tab_code} = {5'd13, 16'd12};
      {5'd11, 2'd0}: {tab_len, tab_code} = {5'd15, 16'd15};
      {5'd11, 2'd1}: {tab_len, tab_code} = {5'd15, 16'd14};
      {5'd11, 2'd2}: {tab_len, tab_code} = {5'd14, 16'd9};
      {5'd11, 2'd3}: {tab_len, tab_code} = {5'd14, 16'd12};
      {5'd12, 2'd0}: {tab_len, tab_code} = {5'd15, 16'd11};
      {5'd12, 2'd1}: {tab_len, tab_code} = {5'd15, 16'd10};
      {5'd12, 2'd2}: {tab_len, tab_code} = {5'd15, 16'd13};
      {5'd12, 2'd3}: {tab_len, tab_code} = {5'd14, 16'd8};
      {5'd13, 2'd0}: {tab_len, tab_code} = {5'd16, 16'd15};
      {5'd13, 2'd1}: {tab_len, tab_code} = {5'd15, 16'd1};
      {5'd13, 2'd2}: {tab_len, tab_code} = {5'd15, 16'd9};
      {5'd13, 2'd3}: {tab_len, tab_code} = {5'd15, 16'd12};
      {5'd14, 2'd0}: {tab_len, tab_code} = {5'd16, 16'd11};
      {5'd14, 2'd1}: {tab_len, tab_code} = {5'd16, 16'd14};
      {5'd14, 2'd2}: {tab_len, tab_code} = {5'd16, 16'd13};
      {5'd14, 2'd3}: {tab_len, tab_code} = {5'd15, 16'd8};
      {5'd15, 2'd0}: {tab_len, tab_code} = {5'd16, 16'd7};
      {5'd15, 2'd1}: {tab_len, tab_code} = {5'd16, 16'd10};
      {5'd15, 2'd2}: {tab_len, tab_code} = {5'd16, 16'd9};
      {5'd15, 2'd3}: {tab_len, tab_code} = {5'd16, 16'd12};
      {5'd16, 2'd0}: {tab_len, tab_code} = {5'd16, 16'd4};
      {5'd16, 2'd1}: {tab_len, tab_code} = {5'd16, 16'd6};
      {5'd16, 2'd2}: {tab_len, tab_code} = {5'd16, 16'd5};
      {5'd16, 2'd3}: {tab_len, tab_code} = {5'd16, 16'd8};
      default:       {tab_len, tab_code} = {5'd0,  16'd0};
    endcase
  end

  always_comb begin : next_state
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (TokenValid) begin
        if (tab_len == 5'd0) begin
          // Illegal token: consumed, flagged, nothing emitted.
          err_d = 1'b1;
        end else begin
          // Left-align so the codeword MSB sits at the shift-out position.
          shreg_d = MAX_LEN'(tab_code) << (MAX_LEN - int'(tab_len));
          cnt_d   = LEN_W'(tab_len);
          state_d = ST_SHIFT;
        end
      end
    end else begin
      if (BitReady) begin
        shreg_d = {shreg_q[MAX_LEN-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state so reset drops BitValid at once.
  assign TokenReady = (state_q == ST_IDLE);
  assign BitValid   = (state_q == ST_SHIFT);
  assign BitOut     = BitValid & shreg_q[MAX_LEN-1];
  assign BitLast    = BitValid & (cnt_q == LEN_W'(1));
  assign TokenErr   = err_q;

endmodule

// File: tb/tb_cavlc_coeff_token_encoder.sv
// Bench for cavlc_coeff_token_encoder: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// queue-of-bits model driven from a string codeword table.
module tb_cavlc_coeff_token_encoder;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic       TokenValid = 1'b0;
  logic       TokenReady;
  logic [4:0] TotalCoeff = 5'd0;
  logic [1:0] TrailingOnes = 2'd0;
  logic       BitValid;
  logic       BitReady = 1'b0;
  logic       BitOut;
  logic       BitLast;
  logic       TokenErr;

  cavlc_coeff_token_encoder #(.MAX_LEN(16), .LEN_W(5)) dut (
    .Clk(Clk), .nReset(nReset), .TokenValid(TokenValid), .TokenReady(TokenReady),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .BitValid(BitValid),
    .BitReady(BitReady), .BitOut(BitOut), .BitLast(BitLast), .TokenErr(TokenErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got '%s' expected '%s' at %0t", name, act, exp, $time);
    end
  endtask

  // Codeword table as bit strings, index TotalCoeff*4 + TrailingOnes.
  string cw_tab [0:67];
  initial begin
    cw_tab = '{
      "1", "", "", "",
      "000101", "01", "", "",
      "00000111", "000100", "001", "",
      "000000111", "00000110", "0000101", "00011",
      "0000000111", "000000110", "00000101", "000011",
      "00000000111", "0000000110", "000000101", "0000100",
      "0000000001111", "00000000110", "0000000101", "00000100",
      "0000000001011", "0000000001110", "00000000101", "000000100",
      "0000000001000", "0000000001010", "0000000001101", "0000000100",
      "00000000001111", "00000000001110", "0000000001001", "00000000100",
      "00000000001011", "00000000001010", "00000000001101", "0000000001100",
      "000000000001111", "000000000001110", "00000000001001", "00000000001100",
      "000000000001011", "000000000001010", "000000000001101", "00000000001000",
      "0000000000001111", "000000000000001", "000000000001001", "000000000001100",
      "0000000000001011", "0000000000001110", "0000000000001101", "000000000001000",
      "0000000000000111", "0000000000001010", "0000000000001001", "0000000000001100",
      "0000000000000100", "0000000000000110", "0000000000000101", "0000000000001000"
    };
  end

  // Model: bits still to be sent for the current codeword, plus the error pulse.
  bit bq[$];
  bit err_now = 1'b0;

  always @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      bq.delete();
      err_now = 1'b0;
    end else begin
      bit    nerr;
      string s;
      chk("token_ready", TokenReady, bq.size() == 0);
      chk("bit_valid", BitValid, bq.size() != 0);
      chk("bit_last", BitLast, bq.size() == 1);
      chk("token_err", TokenErr, err_now);
      if (bq.size() != 0) begin
        chk("bit_out", BitOut, bq[0]);
        chk("cnt_nonzero_in_shift", dut.cnt_q != 0, 1);
      end
      nerr = 1'b0;
      if (bq.size() != 0) begin
        if (BitReady) bq.delete(0);
      end else if (TokenValid) begin
        if (TotalCoeff <= 16 && TrailingOnes <= TotalCoeff) begin
          s = cw_tab[int'(TotalCoeff) * 4 + int'(TrailingOnes)];
          for (int i = 0; i < s.len(); i++) bq.push_back(s.getc(i) == 8'h31);
        end else begin
          nerr = 1'b1;
        end
      end
      err_now = nerr;
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // Send one legal token and collect its bits. BitReady follows pat, indexed
  // by the number of cycles since acceptance.
  task automatic send(input int tc, input int t1, input bit [3:0] pat, output string got,
                      output int ncyc, output int nhs, output int lastidx,
                      output int unstable, output int busy);
    bit acc, done, hold_v;
    logic hold_b, hold_l;
    acc = 0; done = 0; hold_v = 0; hold_b = 0; hold_l = 0;
    got = ""; ncyc = 0; nhs = 0; lastidx = -1; unstable = 0; busy = 0;
    TokenValid = 1'b1; TotalCoeff = 5'(tc); TrailingOnes = 2'(t1); BitReady = pat[0];
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge Clk);
      if (!acc) begin
        acc = TokenReady;
      end else begin
        ncyc++;
        if (TokenReady) busy++;
        if (hold_v && (BitOut !== hold_b || BitLast !== hold_l)) unstable++;
        hold_v = BitValid && !BitReady;
        hold_b = BitOut;
        hold_l = BitLast;
        if (BitValid && BitReady) begin
          if (BitOut) got = {got, "1"}; else got = {got, "0"};
          if (BitLast) begin lastidx = nhs; done = 1; end
          nhs++;
        end
      end
      step();
      if (acc) TokenValid = 1'b0;
      BitReady = pat[ncyc % 4];
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: token (%0d,%0d) got '%s' expected a complete codeword", tc, t1, got);
    end
  endtask

  initial begin
    string got, stream;
    int ncyc, nhs, lastidx, unstable, busy, cyc, phase, nbits;
    bit started, done;

    // T1: reset held with TokenValid high.
    TokenValid = 1'b1; TotalCoeff = 5'd0; TrailingOnes = 2'd0;
    repeat (3) begin
      @(negedge Clk);
      chk("t1_reset_bitvalid", BitValid, 0);
      chk("t1_reset_tokenerr", TokenErr, 0);
    end
    step();
    nReset = 1'b1; TokenValid = 1'b0;
    @(negedge Clk);
    chk("t1_ready_after_release", TokenReady, 1);
    step();

    // T2: (1,0) with BitReady tied high.
    send(1, 0, 4'b1111, got, ncyc, nhs, lastidx, unstable, busy);
    chk_s("t2_stream", got, "000101");
    chk("t2_cycles", ncyc, 6);
    chk("t2_last_index", lastidx, 5);
    chk("t2_ready_low_while_shifting", busy, 0);
    @(negedge Clk);
    chk("t2_ready_7th_cycle", TokenReady, 1);
    step();

    // T3: (0,0) then (3,3) back-to-back; '_' marks a cycle with no bit.
    TokenValid = 1'b1; TotalCoeff = 5'd0; TrailingOnes = 2'd0; BitReady = 1'b1;
    stream = ""; cyc = 0; phase = 0; started = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge Clk);
      if (started) begin
        cyc++;
        if (BitValid) begin
          if (BitOut) stream = {stream, "1"}; else stream = {stream, "0"};
        end else begin
          stream = {stream, "_"};
        end
      end
      if (TokenReady) begin
        if (phase == 0) begin started = 1; phase = 1; end
        else if (phase == 1) phase = 2;
        else done = 1;
      end
      step();
      if (phase == 1) begin TotalCoeff = 5'd3; TrailingOnes = 2'd3; end
      if (phase == 2) TokenValid = 1'b0;
    end
    chk_s("t3_stream", stream, "1_00011_");
    chk("t3_cycles_to_ready", cyc, 8);

    // T4: (2,0) with BitReady 1,0,0,1,...
    send(2, 0, 4'b1001, got, ncyc, nhs, lastidx, unstable, busy);
    chk_s("t4_stream", got, "00000111");
    chk("t4_handshakes", nhs, 8);
    chk("t4_stall_stability", unstable, 0);
    chk("t4_ready_low_while_shifting", busy, 0);

    // T5: illegal (1,2) and (17,0).
    for (int k = 0; k < 2; k++) begin
      TokenValid = 1'b1;
      TotalCoeff = (k == 0) ? 5'd1 : 5'd17;
      TrailingOnes = (k == 0) ? 2'd2 : 2'd0;
      @(negedge Clk);
      chk("t5_ready", TokenReady, 1);
      step();
      TokenValid = 1'b0;
      @(negedge Clk);
      chk("t5_err_pulse", TokenErr, 1);
      chk("t5_no_bits", BitValid, 0);
      step();
      @(negedge Clk);
      chk("t5_err_cleared", TokenErr, 0);
      chk("t5_no_bits_after", BitValid, 0);
      step();
    end

    // T6: reset pulsed during the 3rd bit of (1,0), then (1,1).
    TokenValid = 1'b1; TotalCoeff = 5'd1; TrailingOnes = 2'd0; BitReady = 1'b1;
    started = 0; done = 0; nbits = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Clk);
      if (!started) started = TokenReady;
      else if (BitValid) begin
        nbits++;
        if (nbits == 3) begin
          #1 nReset = 1'b0;
          #1 chk("t6_async_abort", BitValid, 0);
          done = 1;
        end
      end
      step();
      if (started) TokenValid = 1'b0;
    end
    chk("t6_reached_3rd_bit", done, 1);
    nReset = 1'b1;
    send(1, 1, 4'b1111, got, ncyc, nhs, lastidx, unstable, busy);
    chk_s("t6_clean_stream", got, "01");

    // Randomized traffic; inputs change freely, also while shifting.
    for (int c = 0; c < 3000; c++) begin
      TokenValid = ($urandom % 3) != 0;
      TotalCoeff = ($urandom % 10 == 0) ? 5'(17 + $urandom % 15) : 5'($urandom_range(0, 16));
      TrailingOnes = 2'($urandom % 4);
      BitReady = ($urandom % 4) != 0;
      step();
    end
    TokenValid = 1'b0; BitReady = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
